// File: rtl/imem_loader.sv
// Instruction memory with a handshaked load port, session word count / checksum /
// sticky range error, and fetch gating that returns NOOP until the CPU is allowed to run.
//
// state | meaning
// IDLE  | no session; only load_req is honoured
// LOAD  | accepting program words (wr_ready high)
// READY | program loaded, waiting for start or a reload
// RUN   | CPU fetches real instructions
module imem_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     load_req_i,
    input  logic                     auto_inc_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic                     load_done_i,
    input  logic                     start_i,
    output logic                     run_o,
    input  logic [ADDR_W-1:0]        fetch_addr_i,
    output logic [DATA_W-1:0]        fetch_data_o,
    output logic [$clog2(DEPTH):0]   word_count_o,
    output logic [DATA_W-1:0]        checksum_o,
    output logic                     err_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, READY, RUN} state_t;

    state_t              state_q;
    logic                wr_ready_q;
    logic                run_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   sum_q;
    logic                err_q;
    logic [DATA_W-1:0]   fetch_data_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [ADDR_W-1:0]   tgt_addr_d;
    logic                wr_in_range_d;
    logic                accept_d;
    logic                wr_en_d;
    logic                fetch_in_range_d;

    assign tgt_addr_d       = auto_inc_i ? ptr_q : wr_addr_i;
    assign wr_in_range_d    = {1'b0, tgt_addr_d} < DEPTH_X;
    assign accept_d         = wr_valid_i & wr_ready_q;
    assign wr_en_d          = accept_d & wr_in_range_d;
    assign fetch_in_range_d = {1'b0, fetch_addr_i} < DEPTH_X;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            wr_ready_q <= 1'b0;
            run_q      <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_req_i) begin
                        state_q    <= LOAD;
                        wr_ready_q <= 1'b1;
                        ptr_q      <= '0;
                        cnt_q      <= '0;
                        sum_q      <= '0;
                        err_q      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept_d) begin
                        if (wr_in_range_d) begin
                            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
                            sum_q <= sum_q + wr_data_i;
                        end else begin
                            err_q <= 1'b1;
                        end
                        // pointer advances even on rejected writes so a stream stays aligned
                        if (auto_inc_i) ptr_q <= ptr_q + 1'b1;
                    end
                    if (load_done_i) begin
                        state_q    <= READY;
                        wr_ready_q <= 1'b0;
                    end
                end
                READY: begin
                    if (load_req_i) begin
                        state_q    <= LOAD;
                        wr_ready_q <= 1'b1;
                        ptr_q      <= '0;
                        cnt_q      <= '0;
                        sum_q      <= '0;
                        err_q      <= 1'b0;
                    end else if (start_i) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (!start_i) begin
                        state_q <= READY;
                        run_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    wr_ready_q <= 1'b0;
                    run_q      <= 1'b0;
                end
            endcase
        end
    end

    // Memory has no reset; contents survive both reset and reloads.
    always_ff @(posedge clk_i) begin
        if (wr_en_d) mem_q[tgt_addr_d[IDX_W-1:0]] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_data_q <= '0;
        end else if (state_q == RUN && fetch_in_range_d) begin
            fetch_data_q <= mem_q[fetch_addr_i[IDX_W-1:0]];
        end else begin
            fetch_data_q <= '0;
        end
    end

    assign wr_ready_o   = wr_ready_q;
    assign run_o        = run_q;
    assign fetch_data_o = fetch_data_q;
    assign word_count_o = cnt_q;
    assign checksum_o   = sum_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, gating, range errors, reset abort, reload.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_req = 1'b0;
    logic        auto_inc = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic [15:0] wr_addr = '0;
    logic        load_done = 1'b0;
    logic        start = 1'b0;
    logic        run;
    logic [15:0] fetch_addr = '0;
    logic [31:0] fetch_data;
    logic [6:0]  word_count;
    logic [31:0] checksum;
    logic        err;

    int checks = 0;
    int failures = 0;

    logic [31:0] words [27];
    logic [31:0] exp_sum;

    imem_loader #(.DATA_W(32), .ADDR_W(16), .DEPTH(64)) dut (
        .clk_i(clk), .rst_i(rst), .load_req_i(load_req), .auto_inc_i(auto_inc),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
        .wr_addr_i(wr_addr), .load_done_i(load_done), .start_i(start), .run_o(run),
        .fetch_addr_i(fetch_addr), .fetch_data_o(fetch_data), .word_count_o(word_count),
        .checksum_o(checksum), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 27; i++) words[i] = 32'h1357_0000 + 32'(i) * 32'h0101_0003;
        words[1] = 32'hC821_0005;
        exp_sum = '0;
        for (int i = 0; i < 27; i++) exp_sum = exp_sum + words[i];

        // reset state
        #1;
        check("rst_wr_ready", wr_ready, 0);
        check("rst_run", run, 0);
        check("rst_fetch", fetch_data, 0);
        check("rst_count", word_count, 0);
        check("rst_sum", checksum, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
        tick();

        // sequential load of 27 words
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check("load_wr_ready", wr_ready, 1);
        auto_inc = 1'b1;
        for (int i = 0; i < 27; i++) begin
            wr_valid = 1'b1;
            wr_data  = words[i];
            tick();
        end
        wr_valid  = 1'b0;
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check("seq_wr_ready_low", wr_ready, 0);
        check("seq_count", word_count, 27);
        check("seq_sum", checksum, exp_sum);
        check("seq_err", err, 0);

        // start gating
        fetch_addr = 16'd1;
        tick();
        check("gate_pre_start", fetch_data, 0);
        start = 1'b1;
        tick();
        check("gate_run_rise", run, 1);
        check("gate_first_cycle", fetch_data, 0);
        tick();
        check("gate_fetch1", fetch_data, 32'hC821_0005);
        fetch_addr = 16'd3;
        tick();
        check("gate_fetch3", fetch_data, words[3]);
        fetch_addr = 16'd64;
        tick();
        check("gate_fetch_oor", fetch_data, 0);
        fetch_addr = 16'd1;
        start = 1'b0;
        tick();
        check("gate_run_fall", run, 0);
        tick();
        check("gate_after_stop", fetch_data, 0);

        // reload from READY with start and load_req together
        start    = 1'b1;
        load_req = 1'b1;
        tick();
        start    = 1'b0;
        load_req = 1'b0;
        check("reload_wr_ready", wr_ready, 1);
        check("reload_run", run, 0);
        check("reload_count", word_count, 0);
        check("reload_sum", checksum, 0);
        tick();
        check("reload_run_stays", run, 0);

        // explicit out-of-range write, then in-range write
        auto_inc = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 16'd64;
        wr_data  = 32'hFFFF_FFFF;
        tick();
        check("oor_err", err, 1);
        check("oor_count", word_count, 0);
        check("oor_sum", checksum, 0);
        wr_addr = 16'd2;
        wr_data = 32'h0000_1234;
        tick();
        check("inr_err_sticky", err, 1);
        check("inr_count", word_count, 1);
        check("inr_sum", checksum, 32'h0000_1234);

        // write coinciding with load_done
        wr_addr   = 16'd5;
        wr_data   = 32'hDEAD_BEEF;
        load_done = 1'b1;
        tick();
        wr_valid  = 1'b0;
        load_done = 1'b0;
        check("done_wr_ready", wr_ready, 0);
        check("done_count", word_count, 2);
        check("done_sum", checksum, 32'hDEAD_D123);

        start = 1'b1;
        tick();
        check("done_run", run, 1);
        fetch_addr = 16'd0;
        tick();
        check("mem0_untouched", fetch_data, words[0]);
        fetch_addr = 16'd5;
        tick();
        check("mem5_done_write", fetch_data, 32'hDEAD_BEEF);
        fetch_addr = 16'd2;
        tick();
        check("mem2_inrange", fetch_data, 32'h0000_1234);
        start = 1'b0;
        tick();
        tick();

        // reset mid-load after 10 words
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        auto_inc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hA000_0000 + 32'(i);
            tick();
        end
        check("mid_count10", word_count, 10);
        wr_data = 32'hBAD0_BAD0;
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_wr_ready", wr_ready, 0);
        check("mid_rst_count", word_count, 0);
        tick();
        wr_valid = 1'b0;
        rst = 1'b1;
        start = 1'b1;
        tick();
        check("mid_idle_ignores_start", run, 0);
        check("mid_idle_no_ready", wr_ready, 0);
        start = 1'b0;
        load_req = 1'b1;
        tick();
        load_req  = 1'b0;
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        start = 1'b1;
        tick();
        check("mid_run", run, 1);
        fetch_addr = 16'd10;
        tick();
        check("mid_mem10_kept", fetch_data, words[10]);
        fetch_addr = 16'd26;
        tick();
        check("mid_mem26_kept", fetch_data, words[26]);
        fetch_addr = 16'd9;
        tick();
        check("mid_mem9_new", fetch_data, 32'hA000_0009);
        start = 1'b0;
        tick();

        // word_count saturation with repeated overwrites of address 0
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        auto_inc = 1'b0;
        wr_addr  = 16'd0;
        wr_data  = 32'd1;
        wr_valid = 1'b1;
        for (int i = 0; i < 65; i++) tick();
        wr_valid = 1'b0;
        check("sat_count", word_count, 64);
        check("sat_sum", checksum, 65);
        check("sat_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised instruction-memory block with a managed load port, which replaces the bare write-enable/address/data load path into the CPU's instruction memory. Program words stream in over a valid/ready handshake, in auto-increment or explicit-address mode, and the block keeps a word count, a running checksum and a sticky range error. The block gates execution: the CPU fetch port returns NOOP (all zeros) until the program is loaded and `start` is asserted.

## Interface
- `DATA_W`, 32, instruction word width
- `ADDR_W`, 16, width of the write and fetch address ports
- `DEPTH`, 64, number of memory words; legal addresses are 0..DEPTH-1; DEPTH ≤ 2^ADDR_W
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `load_req`  in  1  opens a load session
- `auto_inc`  in  1  1: write address comes from the internal pointer; 0: it comes from `wr_addr`
- `wr_valid`  in  1  a write word is presented
- `wr_ready`  out  1  the block accepts writes
- `wr_data`  in  DATA_W  instruction word to write
- `wr_addr`  in  ADDR_W  explicit write address
- `load_done`  in  1  closes the load session
- `start`  in  1  level; execution is enabled while high
- `run`  out  1  CPU may fetch and execute
- `fetch_addr`  in  ADDR_W  CPU fetch address (word index)
- `fetch_data`  out  DATA_W  fetched instruction, registered
- `word_count`  out  $clog2(DEPTH)+1  accepted in-range writes this session
- `checksum`  out  DATA_W  sum of accepted in-range words, modulo 2^DATA_W
- `err`  out  1  sticky; an out-of-range write was attempted this session

## Operation
- FSM states: IDLE, LOAD, READY, RUN.
- **IDLE**
  - `load_req` moves to LOAD.
  - All other inputs are ignored.
- **LOAD**
  - `wr_ready` = 1.
  - A handshake (`wr_valid & wr_ready`) accepts one word.
  - Target address = `auto_inc ? ptr : wr_addr`.
  - In range: the word is written, `word_count` += 1 and `checksum` += `wr_data`.
  - Out of range: no write; `err` is set; count and checksum are unchanged.
  - `ptr` increments on every accepted handshake in auto_inc mode, in range or not.
  - `load_done` moves to READY. A handshake in the same cycle as `load_done` is still accepted.
- **READY**
  - `start` = 1 moves to RUN.
  - `load_req` moves to LOAD. This reload clears `ptr`, `word_count`, `checksum` and `err`; memory contents are kept.
  - If `start` and `load_req` are both high, `load_req` wins.
- **RUN**
  - `run` = 1.
  - `start` = 0 returns to READY.
  - `load_req` is ignored.
- Entering LOAD from IDLE also clears `ptr`, `word_count`, `checksum` and `err`.
- **Fetch**
  - Synchronous read.
  - `fetch_data` = mem[`fetch_addr`] when the state was RUN in the sampling cycle and the address is in range; otherwise 0 (NOOP).
- Overwriting an address already written in this session still adds to `checksum` and `word_count`.
- `word_count` saturates at DEPTH and does not wrap.
- `ptr` wraps modulo 2^ADDR_W. Writes past DEPTH therefore error until the pointer wraps; `err` stays sticky.

## Timing
- Reset values:
  - State = IDLE, `run` = 0, `wr_ready` = 0.
  - `fetch_data` = 0, `word_count` = 0, `checksum` = 0, `err` = 0, `ptr` = 0.
- Reset does not clear the memory array.
- Reset mid-load aborts the session immediately (asynchronously). The word presented in that cycle is not written.
- `wr_ready` is a registered decode of the state. It rises the cycle after `load_req` is sampled in IDLE or READY, and falls the cycle after `load_done` is sampled.
- Throughput: one word per cycle while in LOAD.
- `word_count`, `checksum` and `err` update on the edge that accepts the write.
- `run` rises one cycle after `start` is sampled high in READY and falls one cycle after `start` is sampled low.
- Fetch latency: 1 cycle. The first valid instruction appears on the edge after the first RUN-cycle fetch address is presented.
- A write and a fetch to the same address never coincide, because writes only occur in LOAD and fetches only return data in RUN.

## Test plan
- **Sequential load.** DEPTH=64, `auto_inc`=1. Stream 27 words (word1 = 0xC8210005, others arbitrary), then `load_done`. Required: `word_count`=27, `checksum` = modular sum of the 27 words, `err`=0, state READY.
- **Start gating.** Before `start`, `fetch_addr`=1 → `fetch_data`=0. Raise `start`; one cycle after `run` rises, `fetch_addr`=1 → `fetch_data`=0xC8210005 on the next edge. Drop `start` → `fetch_data`=0.
- **Explicit out-of-range write.** `auto_inc`=0, `wr_addr`=64 → `err`=1; `word_count` and `checksum` unchanged; mem[0] untouched. A following in-range write still succeeds, and `err` stays 1.
- **Simultaneous `load_done` with a write.** `load_done` and `wr_valid` high in the same cycle, `wr_addr`=5, data 0xDEADBEEF → the word is written, `word_count` increments, and the next state is READY.
- **Reset mid-load.** Drop `rst` after 10 words → `wr_ready`=0, `word_count`=0, state IDLE. After a reload, the earlier contents of addresses 10+ are still readable in RUN.
- **Reload from READY.** Assert `start` and `load_req` together in READY → the block enters LOAD, not RUN; count and checksum clear; `run` stays 0.
